// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields (R/I/S/B/U/J) into a 32-bit
// instruction word and tags it with a sequential instruction-memory write address.
// Input side is valid/ready; output is a one-entry registered stage with valid/ready.
// Optional build macro INSTR_ENC_IMM_CHECK_EN: flags illegal immediates in err.

package instr_pkg;
  typedef enum logic [2:0] {
    INSTR_TYPE_R       = 3'd0,
    INSTR_TYPE_I       = 3'd1,
    INSTR_TYPE_S       = 3'd2,
    INSTR_TYPE_B       = 3'd3,
    INSTR_TYPE_U       = 3'd4,
    INSTR_TYPE_J       = 3'd5,
    INSTR_TYPE_UNKNOWN = 3'd6
  } instr_type_enum;
endpackage

module instr_encoder
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  instr_type_enum             instr_type,
  input  logic [6:0]                 opcode,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                instr,
  output logic [31:0]                addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int          CW        = $clog2(DEPTH + 1);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  // Field packing for each instruction format; unknown types encode to zero.
  function automatic logic [31:0] encode_word(
    input instr_type_enum t,
    input logic [6:0]     op,
    input logic [4:0]     f_rd,
    input logic [4:0]     f_rs1,
    input logic [4:0]     f_rs2,
    input logic [2:0]     f_funct3,
    input logic [6:0]     f_funct7,
    input logic [31:0]    f_imm
  );
    logic [31:0] w;
    case (t)
      INSTR_TYPE_R: w = {f_funct7, f_rs2, f_rs1, f_funct3, f_rd, op};
      INSTR_TYPE_I: w = {f_imm[11:0], f_rs1, f_funct3, f_rd, op};
      INSTR_TYPE_S: w = {f_imm[11:5], f_rs2, f_rs1, f_funct3, f_imm[4:0], op};
      INSTR_TYPE_B: w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f_funct3,
                         f_imm[4:1], f_imm[11], op};
      INSTR_TYPE_U: w = {f_imm[31:12], f_rd, op};
      INSTR_TYPE_J: w = {f_imm[20], f_imm[10:1], f_imm[11], f_imm[19:12], f_rd, op};
      default:      w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // True for any type code outside the six real formats.
  function automatic logic is_unknown(input instr_type_enum t);
    logic u;
    case (t)
      INSTR_TYPE_R, INSTR_TYPE_I, INSTR_TYPE_S,
      INSTR_TYPE_B, INSTR_TYPE_U, INSTR_TYPE_J: u = 1'b0;
      default:                                  u = 1'b1;
    endcase
    return u;
  endfunction

`ifdef INSTR_ENC_IMM_CHECK_EN
  // True when the immediate cannot be represented exactly in the chosen format.
  function automatic logic imm_illegal(input instr_type_enum t, input logic [31:0] v);
    logic bad;
    case (t)
      INSTR_TYPE_I, INSTR_TYPE_S: bad = (v[31:11] != {21{v[11]}});
      INSTR_TYPE_B:               bad = (v[31:12] != {20{v[12]}}) || v[0];
      INSTR_TYPE_J:               bad = (v[31:20] != {12{v[20]}}) || v[0];
      INSTR_TYPE_U:               bad = (v[11:0] != 12'h000);
      default:                    bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic          out_valid_r;
  logic [31:0]   instr_r;
  logic [31:0]   addr_r;
  logic [31:0]   wptr_r;
  logic [CW-1:0] count_r;
  logic          err_r;

  logic          in_ready_s;
  logic          accept_s;
  logic          out_fire_s;
  logic [31:0]   enc_s;
  logic          bad_s;

  // Handshake qualification, word encoding and error detection for the current input.
  always_comb begin
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    out_fire_s = 1'b0;
    enc_s      = 32'h0000_0000;
    bad_s      = 1'b0;
    if (clear) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !out_valid_r || out_ready;
    end
    accept_s   = in_valid && in_ready_s;
    out_fire_s = out_valid_r && out_ready;
    enc_s      = encode_word(instr_type, opcode, rd, rs1, rs2, funct3, funct7, imm);
`ifdef INSTR_ENC_IMM_CHECK_EN
    bad_s      = is_unknown(instr_type) || imm_illegal(instr_type, imm);
`else
    bad_s      = is_unknown(instr_type);
`endif
  end

  // One-entry output register: load on accept, drain on sink handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      instr_r     <= 32'h0000_0000;
      addr_r      <= BASE_ADDR;
    end else if (clear) begin
      out_valid_r <= 1'b0;
      instr_r     <= 32'h0000_0000;
      addr_r      <= BASE_ADDR;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      instr_r     <= enc_s;
      addr_r      <= wptr_r;
    end else if (out_fire_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Write pointer: advances by one word per accept, wrapping after DEPTH words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r <= BASE_ADDR;
    end else if (clear) begin
      wptr_r <= BASE_ADDR;
    end else if (accept_s) begin
      if (wptr_r == LAST_ADDR) begin
        wptr_r <= BASE_ADDR;
      end else begin
        wptr_r <= wptr_r + 32'd4;
      end
    end else begin
      wptr_r <= wptr_r;
    end
  end

  // Emitted-word counter, saturating so it never rolls back past DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (out_fire_s && (count_r != COUNT_MAX)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Sticky error flag, set by any accepted word that could not be encoded faithfully.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (clear) begin
      err_r <= 1'b0;
    end else if (accept_s && bad_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign instr     = instr_r;
  assign addr      = addr_r;
  assign count     = count_r;
  assign err       = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder (DEPTH=4 so address wrap and count
// saturation are reached quickly). Optional macro INSTR_ENC_IMM_CHECK_EN
// switches the expected err value for the immediate-legality vectors.

module tb_instr_encoder;
  import instr_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk;
  logic           reset;
  logic           clear;
  logic           in_valid;
  logic           in_ready;
  instr_type_enum instr_type;
  logic [6:0]     opcode;
  logic [4:0]     rd, rs1, rs2;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic [31:0]    imm;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    instr;
  logic [31:0]    addr;
  logic [CW-1:0]  count;
  logic           err;

  int n_checks;
  int n_pass;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_type(instr_type), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .addr(addr), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a field set without waiting for an edge.
  task automatic drive(input instr_type_enum t, input logic [6:0] op, input logic [4:0] f_rd,
                       input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] f_imm);
    instr_type = t; opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
    funct3 = f3; funct7 = f7; imm = f_imm; in_valid = 1'b1;
  endtask

  // Present a field set for one edge and return at edge+1.
  task automatic send(input instr_type_enum t, input logic [6:0] op, input logic [4:0] f_rd,
                      input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] f_imm);
    drive(t, op, f_rd, f_rs1, f_rs2, f3, f7, f_imm);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr_type = INSTR_TYPE_R; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr",     instr,              32'h0000_0000);
    check("rst_addr",      addr,               32'h0000_0000);
    check("rst_count",     32'(count),         32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Back-to-back encodes with out_ready=1; six words wrap the 4-word window
    send(INSTR_TYPE_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("r_valid", {31'd0, out_valid}, 32'd1);
    check("r_instr", instr, 32'h0020_81B3);
    check("r_addr",  addr,  32'h0000_0000);
    check("r_count", 32'(count), 32'd0);
    send(INSTR_TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("i_instr", instr, 32'h0050_0093);
    check("i_addr",  addr,  32'h0000_0004);
    check("i_count", 32'(count), 32'd1);
    send(INSTR_TYPE_S, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    check("s_instr", instr, 32'h0020_A423);
    check("s_addr",  addr,  32'h0000_0008);
    send(INSTR_TYPE_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    check("u_instr", instr, 32'h1234_52B7);
    check("u_addr",  addr,  32'h0000_000C);
    check("u_count", 32'(count), 32'd3);
    send(INSTR_TYPE_B, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    check("b_instr", instr, 32'hFE00_0EE3);
    check("b_addr_wrap", addr, 32'h0000_0000);
    check("b_count", 32'(count), 32'd4);
    send(INSTR_TYPE_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    check("j_instr", instr, 32'h0080_00EF);
    check("j_addr",  addr,  32'h0000_0004);
    check("j_count_sat", 32'(count), 32'd4);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("sat_count",   32'(count), 32'd4);
    check("ok_err",      {31'd0, err}, 32'd0);

    // Clear restores address/count
    pulse_clear();
    check("clr_addr",  addr, 32'h0000_0000);
    check("clr_count", 32'(count), 32'd0);

    // Clear has priority: a simultaneous input is not consumed
    drive(INSTR_TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    clear = 1'b1;
    #1;
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_no_accept", {31'd0, out_valid}, 32'd0);

    // Backpressure: first word held, second waits
    out_ready = 1'b0;
    drive(INSTR_TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    #1;
    check("bp_ready_empty", {31'd0, in_ready}, 32'd1);
    tick();
    drive(INSTR_TYPE_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    #1;
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_instr0",   instr, 32'h0050_0093);
    tick(); tick();
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_instr", instr, 32'h0050_0093);
    check("bp_hold_addr",  addr,  32'h0000_0000);
    out_ready = 1'b1;
    #1;
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_instr1", instr, 32'h0020_81B3);
    check("bp_addr1",  addr,  32'h0000_0004);
    check("bp_count1", 32'(count), 32'd1);
    tick();
    check("bp_count2", 32'(count), 32'd2);
    check("bp_empty",  {31'd0, out_valid}, 32'd0);

    // Unknown type: emitted as zero, err sticky
    send(INSTR_TYPE_UNKNOWN, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("unk_valid", {31'd0, out_valid}, 32'd1);
    check("unk_instr", instr, 32'h0000_0000);
    check("unk_err",   {31'd0, err}, 32'd1);
    send(INSTR_TYPE_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("err_sticky", {31'd0, err}, 32'd1);
    pulse_clear();
    check("clr_err",       {31'd0, err}, 32'd0);
    check("clr_err_addr",  addr, 32'h0000_0000);
    check("clr_err_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    send(INSTR_TYPE_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_instr", instr, 32'h0000_0000);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();

    // Immediate legality vectors; words are still emitted truncated
    send(INSTR_TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    check("i4096_instr", instr, 32'h0000_0093);
`ifdef INSTR_ENC_IMM_CHECK_EN
    check("i4096_err", {31'd0, err}, 32'd1);
`else
    check("i4096_err", {31'd0, err}, 32'd0);
`endif
    pulse_clear();
    send(INSTR_TYPE_B, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    check("b3_instr", instr, 32'h0000_0163);
`ifdef INSTR_ENC_IMM_CHECK_EN
    check("b3_err", {31'd0, err}, 32'd1);
`else
    check("b3_err", {31'd0, err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's opcode/instruction-type decode path: packs decoded fields into a 32-bit RV32I instruction word.
- Pairs each word with a sequential instruction-memory write address, for self-checking program generation and the boot/program loader.
- Valid/ready input side feeding a one-entry registered output stage with valid/ready.
- Drives the instruction-memory write port, or a decoder-compare scoreboard in test.

Parameters:
- BASE_ADDR, 32'h0000_0000, address of first emitted word; must be 4-byte aligned.
- DEPTH, 256, number of words before address wrap; must be ≥1.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous: address/count back to BASE_ADDR/0, drops out_valid, clears err.
- in_valid  input  1  field set valid.
- in_ready  output  1  field set accepted when in_valid && in_ready.
- instr_type  input  instr_type_enum  INSTR_TYPE_R/I/S/B/U/J/UNKNOWN from the shared package.
- opcode  input  7  inserted verbatim in bits [6:0].
- rd, rs1, rs2  input  5 each  register fields.
- funct3  input  3.
- funct7  input  7.
- imm  input  32  immediate, byte offset, sign-extended form.
- out_valid  output  1  instr/addr valid.
- out_ready  input  1  sink accepts when out_valid && out_ready.
- instr  output  32  encoded word.
- addr  output  32  write address of instr.
- count  output  $clog2(DEPTH+1)  words emitted since reset/clear, saturating at DEPTH.
- err  output  1  sticky error flag.

Behaviour:
- Reset values: out_valid=0, instr=0, addr=BASE_ADDR, count=0, err=0.
- in_ready = !out_valid || out_ready, combinational. This gives full throughput and no bubble on back-to-back transfers.
- Latency is 1 cycle: accept at edge N, and instr/out_valid are visible after edge N.
- While out_valid && !out_ready, instr and addr hold stable and no input is accepted.
- Encoding (opcode = bits [6:0]):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Unused input fields are ignored.
- INSTR_TYPE_UNKNOWN: the word is still accepted, emitted as 32'h0000_0000, and err is set.
- Address pointer (internal wptr):
  - Each accepted input is tagged with the current wptr, which is registered into addr.
  - wptr then advances by 4.
  - After the word at BASE_ADDR+4*(DEPTH-1), wptr wraps to BASE_ADDR.
- count increments on each output handshake and saturates at DEPTH. The address still wraps after saturation.
- clear:
  - Has priority over a simultaneous accept; that input is not consumed (in_ready forced 0 while clear=1).
  - A pending output word is discarded.
- reset mid-transfer: the pending word is lost and all outputs return to reset values immediately (asynchronous).
- err is sticky until reset or clear.

Optional Feature:
- Macro: INSTR_ENC_IMM_CHECK_EN.
- Defined: immediate legality is checked on accept; an illegal immediate sets err and the word is still emitted, truncated as normal.
  - I and S types: imm must be a sign-extension of 12 bits.
  - B type: 13 bits with imm[0]=0.
  - J type: 21 bits with imm[0]=0.
  - U type: imm[11:0]=0.
- Undefined: no immediate checks; err is raised only by UNKNOWN type.

Test Plan:
- Basic encodes, out_ready=1 throughout:
  - R, opcode 0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> instr 0x002081B3, addr 0x0.
  - I, opcode 0010011, rd=1, rs1=0, imm=5 -> instr 0x00500093, addr 0x4 the next cycle.
- Store and upper-immediate encodes:
  - S, opcode 0100011, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423.
  - U, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7.
- Control-transfer encodes:
  - B, opcode 1100011, rs1=rs2=0, funct3=0, imm=-4 -> 0xFE000EE3.
  - J, opcode 1101111, rd=1, imm=8 -> 0x008000EF.
- Backpressure: hold out_ready=0 and present 2 valid inputs -> first word held stable, in_ready=0, second not consumed. Raise out_ready -> both words emitted in order on consecutive cycles, addr 0x0 then 0x4.
- Wrap with DEPTH=4: emit 6 words -> addr sequence 0,4,8,C,0,4; count saturates at 4.
- Error and control:
  - UNKNOWN type -> instr=0 and err=1 held.
  - clear -> err=0, addr=BASE_ADDR.
  - reset asserted while out_valid=1 -> out_valid=0 without waiting for a clock edge.
  - With INSTR_ENC_IMM_CHECK_EN: I-type imm=4096 and B-type imm=3 each set err.
